// File: rtl/cpu_6502_addr_seq_pkg.sv
// Shared ISA types for the 6502 operand/effective-address sequencer:
// addressing modes, sequencer states and the memory-address mux select.
package cpu_6502_addr_seq_pkg;

    typedef enum logic [3:0] {
        IMPLIED           = 4'd0,
        ACCUMULATOR       = 4'd1,
        IMMEDIATE         = 4'd2,
        ZERO_PAGE         = 4'd3,
        ZERO_PAGE_X       = 4'd4,
        ZERO_PAGE_Y       = 4'd5,
        RELATIVE          = 4'd6,
        ABSOLUTE          = 4'd7,
        ABSOLUTE_X        = 4'd8,
        ABSOLUTE_Y        = 4'd9,
        INDIRECT_X        = 4'd10,
        INDIRECT_Y        = 4'd11,
        ABSOLUTE_INDIRECT = 4'd12
    } addressing_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FOP1   = 3'd1,
        FOP2   = 3'd2,
        IND_LO = 3'd3,
        IND_HI = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    typedef enum logic {
        PC_FETCH_ADDRESS = 1'b0,
        ALU_ADDRESS      = 1'b1
    } ctrl_mux_mem_addr_t;

    // Unused encodings behave as IMPLIED so they never start a bus cycle.
    function automatic addressing_mode_t decode_mode(input logic [3:0] raw);
        return (raw > 4'd12) ? IMPLIED : addressing_mode_t'(raw);
    endfunction

    function automatic logic is_implied(input addressing_mode_t m);
        return (m == IMPLIED) || (m == ACCUMULATOR);
    endfunction

    function automatic logic has_second_operand(input addressing_mode_t m);
        case (m)
            ABSOLUTE, ABSOLUTE_X, ABSOLUTE_Y, ABSOLUTE_INDIRECT: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    function automatic logic has_pointer(input addressing_mode_t m);
        case (m)
            INDIRECT_X, INDIRECT_Y, ABSOLUTE_INDIRECT: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_6502_ea_calc.sv
// Combinational pointer-address and effective-address arithmetic for every
// addressing mode, including zero-page and indirect-JMP page-wrap quirks.
module cpu_6502_ea_calc
    import cpu_6502_addr_seq_pkg::*;
(
    input  addressing_mode_t mode_i,
    input  logic [15:0]      pc_i,
    input  logic [7:0]       op_lo_i,
    input  logic [7:0]       op_hi_i,
    input  logic [7:0]       ptr_lo_i,
    input  logic [7:0]       ptr_hi_i,
    input  logic [7:0]       x_i,
    input  logic [7:0]       y_i,
    output logic [15:0]      ptr_lo_addr_o,
    output logic [15:0]      ptr_hi_addr_o,
    output logic [15:0]      ea_o
);

    logic [7:0]  w_zp_x;
    logic [7:0]  w_zp_y;
    logic [15:0] w_abs;
    logic [15:0] w_ptr;

    assign w_zp_x = op_lo_i + x_i;
    assign w_zp_y = op_lo_i + y_i;
    assign w_abs  = {op_hi_i, op_lo_i};
    assign w_ptr  = {ptr_hi_i, ptr_lo_i};

    // Pointer byte addresses; the high byte never carries into the next page.
    always_comb begin
        ptr_lo_addr_o = 16'h0000;
        ptr_hi_addr_o = 16'h0000;
        case (mode_i)
            INDIRECT_X: begin
                ptr_lo_addr_o = {8'h00, w_zp_x};
                ptr_hi_addr_o = {8'h00, w_zp_x + 8'd1};
            end
            INDIRECT_Y: begin
                ptr_lo_addr_o = {8'h00, op_lo_i};
                ptr_hi_addr_o = {8'h00, op_lo_i + 8'd1};
            end
            ABSOLUTE_INDIRECT: begin
                ptr_lo_addr_o = w_abs;
                ptr_hi_addr_o = {op_hi_i, op_lo_i + 8'd1};
            end
            default: begin
                ptr_lo_addr_o = 16'h0000;
                ptr_hi_addr_o = 16'h0000;
            end
        endcase
    end

    // Effective address from captured operand/pointer bytes and live index registers.
    always_comb begin
        ea_o = 16'h0000;
        case (mode_i)
            IMMEDIATE:         ea_o = pc_i;
            ZERO_PAGE:         ea_o = {8'h00, op_lo_i};
            ZERO_PAGE_X:       ea_o = {8'h00, w_zp_x};
            ZERO_PAGE_Y:       ea_o = {8'h00, w_zp_y};
            RELATIVE:          ea_o = pc_i + 16'd1 + {{8{op_lo_i[7]}}, op_lo_i};
            ABSOLUTE:          ea_o = w_abs;
            ABSOLUTE_X:        ea_o = w_abs + {8'h00, x_i};
            ABSOLUTE_Y:        ea_o = w_abs + {8'h00, y_i};
            INDIRECT_X:        ea_o = w_ptr;
            INDIRECT_Y:        ea_o = w_ptr + {8'h00, y_i};
            ABSOLUTE_INDIRECT: ea_o = w_ptr;
            default:           ea_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cpu_6502_addr_seq.sv
// Operand-fetch and effective-address sequencer: walks the operand and
// pointer reads for one instruction and pulses ea_valid_o when done.
module cpu_6502_addr_seq
    import cpu_6502_addr_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    input  logic [3:0]  addr_mode_i,
    input  logic [15:0] pc_i,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_addr_sel_o,
    output logic        pc_inc_o,
    output logic [7:0]  operand_o,
    output logic [15:0] ea_o,
    output logic        ea_valid_o,
    output logic        busy_o
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    addressing_mode_t r_mode;
    addressing_mode_t w_new_mode;
    logic [15:0]      r_pc;
    logic [15:0]      r_ea;
    logic [7:0]       r_op_lo;
    logic [7:0]       r_op_hi;
    logic [7:0]       r_ptr_lo;
    logic [7:0]       r_ptr_hi;
    logic [15:0]      w_ptr_lo_addr;
    logic [15:0]      w_ptr_hi_addr;
    logic [15:0]      w_ea;

    assign w_new_mode = decode_mode(addr_mode_i);
    assign operand_o  = r_op_lo;

    cpu_6502_ea_calc u_ea_calc (
        .mode_i        (r_mode),
        .pc_i          (r_pc),
        .op_lo_i       (r_op_lo),
        .op_hi_i       (r_op_hi),
        .ptr_lo_i      (r_ptr_lo),
        .ptr_hi_i      (r_ptr_hi),
        .x_i           (x_i),
        .y_i           (y_i),
        .ptr_lo_addr_o (w_ptr_lo_addr),
        .ptr_hi_addr_o (w_ptr_hi_addr),
        .ea_o          (w_ea)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; fetch states only move on when memory completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (instr_valid_i) begin
                    w_next_state = is_implied(w_new_mode) ? DONE : FOP1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FOP1: begin
                if (!mem_ready_i)                  w_next_state = FOP1;
                else if (has_second_operand(r_mode)) w_next_state = FOP2;
                else if (has_pointer(r_mode))      w_next_state = IND_LO;
                else                               w_next_state = DONE;
            end
            FOP2: begin
                if (!mem_ready_i)             w_next_state = FOP2;
                else if (has_pointer(r_mode)) w_next_state = IND_LO;
                else                          w_next_state = DONE;
            end
            IND_LO:  w_next_state = mem_ready_i ? IND_HI : IND_LO;
            IND_HI:  w_next_state = mem_ready_i ? DONE : IND_HI;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Instruction context and fetched bytes; EA is latched so it holds after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= IMPLIED;
            r_pc     <= 16'h0000;
            r_ea     <= 16'h0000;
            r_op_lo  <= 8'h00;
            r_op_hi  <= 8'h00;
            r_ptr_lo <= 8'h00;
            r_ptr_hi <= 8'h00;
        end else begin
            if (r_state == IDLE && instr_valid_i) begin
                r_mode <= w_new_mode;
                r_pc   <= pc_i;
            end
            case (r_state)
                FOP1:    if (mem_ready_i) r_op_lo  <= mem_rdata_i;
                FOP2:    if (mem_ready_i) r_op_hi  <= mem_rdata_i;
                IND_LO:  if (mem_ready_i) r_ptr_lo <= mem_rdata_i;
                IND_HI:  if (mem_ready_i) r_ptr_hi <= mem_rdata_i;
                DONE:    r_ea <= w_ea;
                default: r_ea <= r_ea;
            endcase
        end
    end

    // Moore-style outputs decoded from state; pc_inc_o also needs the ready handshake.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_addr_o     = 16'h0000;
        mem_addr_sel_o = PC_FETCH_ADDRESS;
        pc_inc_o       = 1'b0;
        ea_valid_o     = 1'b0;
        ea_o           = r_ea;
        busy_o         = 1'b1;
        case (r_state)
            IDLE: busy_o = 1'b0;
            FOP1: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_pc;
                pc_inc_o   = mem_ready_i;
            end
            FOP2: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_pc + 16'd1;
                pc_inc_o   = mem_ready_i;
            end
            IND_LO: begin
                mem_req_o      = 1'b1;
                mem_addr_o     = w_ptr_lo_addr;
                mem_addr_sel_o = ALU_ADDRESS;
            end
            IND_HI: begin
                mem_req_o      = 1'b1;
                mem_addr_o     = w_ptr_hi_addr;
                mem_addr_sel_o = ALU_ADDRESS;
            end
            DONE: begin
                ea_valid_o = 1'b1;
                ea_o       = w_ea;
            end
            default: busy_o = 1'b0;
        endcase
    end

endmodule
